// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: writer FSM states,
// default word widths and the default word-address map of the shared memory.
package conv_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 32;

   localparam logic [31:0] IMG_BASE    = 32'h0000_0000;
   localparam logic [31:0] WEIGHT_BASE = 32'h0000_1000;
   localparam logic [31:0] IM2COL_BASE = 32'h0000_2000;
   localparam logic [31:0] OUTPUT_BASE = 32'h0000_3000;
   localparam logic [31:0] MEM_SIZE    = 32'h0000_4000;

   typedef enum logic [1:0] {
      WAIT_VALID = 2'd0,
      ARMED      = 2'd1,
      RUN        = 2'd2,
      DONE       = 2'd3
   } state_e;

   // Bits needed to index n entries (at least one bit).
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/systolic_out_writer_out_row_buffer.sv
// Row store for captured Y rows: one full-row write port, and a combinational
// read port that selects a single word of one row.
module out_row_buffer
   import conv_pkg::*;
#(
   parameter int M          = 20,
   parameter int K          = 5,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ROW_W      = idx_w(M),
   parameter int WORD_W     = idx_w(K)
) (
   input  logic                    clk,
   input  logic                    wr_en_i,
   input  logic [ROW_W-1:0]        wr_row_i,
   input  logic [DATA_WIDTH*K-1:0] wr_data_i,
   input  logic [ROW_W-1:0]        rd_row_i,
   input  logic [WORD_W-1:0]       rd_word_i,
   output logic [DATA_WIDTH-1:0]   rd_data_o
);

   logic [DATA_WIDTH*K-1:0] rows_q [M];
   logic [DATA_WIDTH*K-1:0] rd_row;

   // Pure data storage: no reset, rows are always written before they are read.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         rows_q[wr_row_i] <= wr_data_i;
      end
   end

   assign rd_row = rows_q[rd_row_i];

   always_comb begin
      rd_data_o = '0;
      for (int k = 0; k < K; k++) begin
         if (rd_word_i == WORD_W'(k)) begin
            rd_data_o = rd_row[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/systolic_out_writer.sv
// Captures M Y rows from the systolic array and writes them back to memory in
// channel-major order, one word per cycle, overlapping drain with capture.
module systolic_out_writer
   import conv_pkg::*;
#(
   parameter int                    M           = 20,
   parameter int                    K           = 5,
   parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int                    ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = ADDR_WIDTH'(conv_pkg::OUTPUT_BASE),
   parameter int                    RELU        = 0
) (
   input  logic                    clk,
   input  logic                    rst_systolic,
   input  logic                    y_valid,
   input  logic [DATA_WIDTH*K-1:0] Y,
   output logic                    mem_wr_en,
   output logic [ADDR_WIDTH-1:0]   addr_wr,
   output logic [DATA_WIDTH-1:0]   data_wr,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam int ROW_W  = idx_w(M);
   localparam int WORD_W = idx_w(K);
   localparam int CAP_W  = idx_w(M + 1);
   localparam int DK_W   = idx_w(K + 1);

   localparam logic [CAP_W-1:0] CAP_FULL = CAP_W'(M);
   localparam logic [ROW_W-1:0] M_LAST   = ROW_W'(M - 1);
   localparam logic [DK_W-1:0]  K_END    = DK_W'(K);

   state_e                  state_q, state_d;
   logic [CAP_W-1:0]        cap_cnt_q, cap_cnt_d;
   logic [ROW_W-1:0]        drain_m_q, drain_m_d;
   logic [DK_W-1:0]         drain_k_q, drain_k_d;
   logic                    wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;

   logic                    buf_wr_en;
   logic [ROW_W-1:0]        buf_wr_row;
   logic [DATA_WIDTH-1:0]   buf_rd_word;
   logic                    issue;

   function automatic logic [DATA_WIDTH-1:0] relu_word(input logic signed [DATA_WIDTH-1:0] w);
      if ((RELU != 0) && (w < 0)) begin
         return '0;
      end
      return w;
   endfunction

   // Row 0 lands on the ARMED exit edge; later rows follow on consecutive RUN edges.
   assign buf_wr_en  = ((state_q == ARMED) && !y_valid) ||
                       ((state_q == RUN) && (cap_cnt_q < CAP_FULL));
   assign buf_wr_row = (state_q == ARMED) ? '0 : ROW_W'(cap_cnt_q);

   out_row_buffer #(
      .M          (M),
      .K          (K),
      .DATA_WIDTH (DATA_WIDTH),
      .ROW_W      (ROW_W),
      .WORD_W     (WORD_W)
   ) u_row_buf (
      .clk       (clk),
      .wr_en_i   (buf_wr_en),
      .wr_row_i  (buf_wr_row),
      .wr_data_i (Y),
      .rd_row_i  (drain_m_q),
      .rd_word_i (WORD_W'(drain_k_q)),
      .rd_data_o (buf_rd_word)
   );

   // A word may be drained only once its row was stored on an earlier edge.
   assign issue = (state_q == RUN) && (drain_k_q < K_END) &&
                  (CAP_W'(drain_m_q) < cap_cnt_q);

   always_comb begin
      state_d   = state_q;
      cap_cnt_d = cap_cnt_q;
      drain_m_d = drain_m_q;
      drain_k_d = drain_k_q;
      wr_en_d   = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;
      err_d     = err_q;

      unique case (state_q)
         WAIT_VALID: begin
            if (y_valid) begin
               state_d = ARMED;
            end
         end
         ARMED: begin
            if (!y_valid) begin
               cap_cnt_d = CAP_W'(1);
               state_d   = RUN;
            end
         end
         RUN: begin
            if (y_valid) begin
               err_d = 1'b1;
            end
            if (cap_cnt_q < CAP_FULL) begin
               cap_cnt_d = cap_cnt_q + CAP_W'(1);
            end
            if (drain_k_q == K_END) begin
               state_d = DONE;
            end else if (issue) begin
               wr_en_d = 1'b1;
               addr_d  = OUTPUT_BASE
                         + ADDR_WIDTH'(drain_k_q) * ADDR_WIDTH'(M)
                         + ADDR_WIDTH'(drain_m_q);
               data_d  = relu_word(buf_rd_word);
               if (drain_m_q == M_LAST) begin
                  drain_m_d = '0;
                  drain_k_d = drain_k_q + DK_W'(1);
               end else begin
                  drain_m_d = drain_m_q + ROW_W'(1);
               end
            end
         end
         DONE: begin
         end
         default: begin
            state_d = WAIT_VALID;
         end
      endcase

      busy_d = (state_d == ARMED) || (state_d == RUN);
      done_d = done_q || (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst_systolic) begin
      if (rst_systolic) begin
         state_q   <= WAIT_VALID;
         cap_cnt_q <= '0;
         drain_m_q <= '0;
         drain_k_q <= '0;
         wr_en_q   <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cap_cnt_q <= cap_cnt_d;
         drain_m_q <= drain_m_d;
         drain_k_q <= drain_k_d;
         wr_en_q   <= wr_en_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign mem_wr_en = wr_en_q;
   assign addr_wr   = addr_q;
   assign data_wr   = data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_systolic_out_writer.sv
// Bench for systolic_out_writer: one instance without and one with RELU share
// stimulus; a per-instance queue of expected writes is compared on each strobe.
module tb_systolic_out_writer;

   localparam int M  = 20;
   localparam int K  = 5;
   localparam int DW = 32;
   localparam int AW = 32;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst_systolic;
   logic          y_valid;
   logic [DW*K-1:0] Y;

   logic          wr_en [2];
   logic [AW-1:0] addr  [2];
   logic [DW-1:0] data  [2];
   logic          busy  [2];
   logic          done  [2];
   logic          err   [2];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int e0       = 0;
   int wr_cnt [2];
   logic [DW-1:0] mem [2][M*K];
   logic [DW-1:0] rows [M][K];
   wr_t q0 [$];
   wr_t q1 [$];

   systolic_out_writer #(
      .M(M), .K(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .OUTPUT_BASE(32'h0000_3000), .RELU(0)
   ) u_dut (
      .clk(clk), .rst_systolic(rst_systolic), .y_valid(y_valid), .Y(Y),
      .mem_wr_en(wr_en[0]), .addr_wr(addr[0]), .data_wr(data[0]),
      .busy(busy[0]), .done(done[0]), .err(err[0])
   );

   systolic_out_writer #(
      .M(M), .K(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .OUTPUT_BASE(32'h0000_3000), .RELU(1)
   ) u_dut_relu (
      .clk(clk), .rst_systolic(rst_systolic), .y_valid(y_valid), .Y(Y),
      .mem_wr_en(wr_en[1]), .addr_wr(addr[1]), .data_wr(data[1]),
      .busy(busy[1]), .done(done[1]), .err(err[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Scoreboard: every strobe pops the next expected write of its instance.
   always @(negedge clk) begin
      wr_t e;
      logic got;
      if (!rst_systolic) begin
         for (int i = 0; i < 2; i++) begin
            if (wr_en[i]) begin
               got = 1'b0;
               e   = '0;
               if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
               if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
               if (!got) begin
                  chk($sformatf("unexpected_wr%0d", i), {32'h0, addr[i]}, 64'hFFFF_FFFF_FFFF_FFFF);
               end else begin
                  chk($sformatf("addr%0d", i), {32'h0, addr[i]}, {32'h0, e.a});
                  chk($sformatf("data%0d", i), {32'h0, data[i]}, {32'h0, e.d});
               end
               chk($sformatf("wr_cycle%0d", i), cyc, e0 + wr_cnt[i] + 1);
               if (addr[i] >= 32'h3000 && addr[i] < 32'h3000 + M*K)
                  mem[i][addr[i] - 32'h3000] = data[i];
               wr_cnt[i]++;
            end
         end
      end
   end

   function automatic logic [DW*K-1:0] pack_row(input int m);
      logic [DW*K-1:0] r;
      for (int k = 0; k < K; k++) r[k*DW +: DW] = rows[m][k];
      return r;
   endfunction

   task automatic check_idle(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s_wr_en%0d", tag, i), wr_en[i], 1'b0);
         chk($sformatf("%s_busy%0d", tag, i), busy[i], 1'b0);
         chk($sformatf("%s_done%0d", tag, i), done[i], 1'b0);
         chk($sformatf("%s_err%0d", tag, i), err[i], 1'b0);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_systolic = 1'b1;
      y_valid = 1'b0;
      @(posedge clk);
      #1;
      check_idle("reset");
      chk("reset_addr0", addr[0], 32'h0);
      chk("reset_data0", data[0], 32'h0);
      rst_systolic = 1'b0;
   endtask

   // One capture/drain pass; optional negative words, y_valid glitch, mid-run reset.
   task automatic run(input bit patch, input bit glitch, input bit abort);
      int n;
      for (int m = 0; m < M; m++)
         for (int k = 0; k < K; k++) rows[m][k] = 32'(16*m + k);
      if (patch) begin
         rows[2][1] = 32'hFFFF_FFF0;
         rows[3][0] = 32'h0000_0007;
         rows[7][4] = 32'h8000_0000;
         rows[8][2] = 32'h7FFF_FFFF;
      end
      q0.delete();
      q1.delete();
      for (int k = 0; k < K; k++)
         for (int m = 0; m < M; m++) begin
            q0.push_back('{a: 32'h3000 + 32'(k*M + m), d: rows[m][k]});
            q1.push_back('{a: 32'h3000 + 32'(k*M + m), d: rows[m][k][DW-1] ? 32'h0 : rows[m][k]});
         end
      for (int i = 0; i < 2; i++) begin
         wr_cnt[i] = 0;
         for (int j = 0; j < M*K; j++) mem[i][j] = 32'hDEAD_BEEF;
      end

      @(posedge clk);
      #1 y_valid = 1'b1;
      Y = {$urandom, $urandom, $urandom, $urandom, $urandom};
      repeat (3) @(posedge clk);
      #1 y_valid = 1'b0;
      Y = pack_row(0);
      e0 = cyc + 1;
      chk("armed_busy", busy[0], 1'b1);
      @(posedge clk);
      #1;
      for (int m = 1; m < M; m++) begin
         Y = pack_row(m);
         if (glitch) y_valid = (m == 10);
         @(posedge clk);
         #1;
      end
      y_valid = 1'b0;
      Y = {$urandom, $urandom, $urandom, $urandom, $urandom};

      if (abort) begin
         repeat (11) @(posedge clk);
         #1 chk("abort_pre_wr_en", wr_en[0], 1'b1);
         #1 rst_systolic = 1'b1;
         #1;
         check_idle("abort");
         chk("abort_wr_cnt", wr_cnt[0], 29);
         q0.delete();
         q1.delete();
         #1 rst_systolic = 1'b0;
      end else begin
         n = 0;
         while (!done[0] && n < 300) begin
            @(negedge clk);
            n++;
         end
         chk("done_seen", done[0], 1'b1);
         chk("done_cycle", cyc, e0 + M*K + 1);
         chk("done_relu", done[1], 1'b1);
         chk("done_wr_en", wr_en[0], 1'b0);
         chk("done_busy", busy[0], 1'b0);
         chk("wr_total0", wr_cnt[0], M*K);
         chk("wr_total1", wr_cnt[1], M*K);
         chk("q_left", q0.size() + q1.size(), 0);
         chk("err_flag", err[0], glitch);
         chk("err_flag_relu", err[1], glitch);
         repeat (5) @(negedge clk);
         chk("done_sticky", done[0], 1'b1);
         chk("err_sticky", err[0], glitch);
      end
   endtask

   initial begin
      rst_systolic = 1'b1;
      y_valid      = 1'b0;
      Y            = '0;
      wr_cnt[0]    = 0;
      wr_cnt[1]    = 0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("por");
      chk("por_addr", addr[0], 32'h0);
      chk("por_data", data[0], 32'h0);
      rst_systolic = 1'b0;

      run(1'b0, 1'b0, 1'b0);
      chk("mem_3000", mem[0][8'h00], 32'h0);
      chk("mem_3015", mem[0][8'h15], 32'h11);
      chk("mem_3063", mem[0][8'h63], 32'h134);
      chk("mem_3013", mem[0][8'h13], 32'h130);
      chk("mem_3014", mem[0][8'h14], 32'h1);

      do_reset();
      run(1'b1, 1'b0, 1'b0);
      chk("relu_neg", mem[1][22], 32'h0);
      chk("relu_pos", mem[1][3], 32'h7);
      chk("relu_min", mem[1][4*M + 7], 32'h0);
      chk("relu_max", mem[1][2*M + 8], 32'h7FFF_FFFF);
      chk("norelu_neg", mem[0][22], 32'hFFFF_FFF0);
      chk("norelu_min", mem[0][4*M + 7], 32'h8000_0000);

      do_reset();
      run(1'b0, 1'b1, 1'b0);

      do_reset();
      run(1'b0, 1'b0, 1'b1);
      run(1'b1, 1'b0, 1'b0);

      do_reset();
      wr_cnt[0] = 0;
      wr_cnt[1] = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk);
         #1 Y = {$urandom, $urandom, $urandom, $urandom, $urandom};
      end
      chk("noarm_writes", wr_cnt[0] + wr_cnt[1], 0);
      chk("noarm_busy", busy[0], 1'b0);
      chk("noarm_done", done[0], 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/systolic_out_writer.md
Name: systolic_out_writer

Overview:
- Sink-side counterpart of im2col: im2col writes the column matrix into memory, this block writes the systolic array's Y rows back into memory at OUTPUT_BASE.
- Captures M consecutive Y rows (K words each) as they emerge from systolic_array.
- Buffers the rows, then serialises them as one memory word per cycle in channel-major (CHW) layout.
- Asserts done when all M*K words are written.

Parameters:
- M, 20, output pixels (IMG_H*IMG_W); number of Y rows.
- K, 5, filters; words per Y row.
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 32, memory address width.
- OUTPUT_BASE, 32'h00003000, base word address of output feature maps.
- RELU, 0, 1 = clamp negative (signed) words to 0 before writing.

Ports:
- clk  input  1  clock.
- rst_systolic  input  1  reset, asynchronous, active-high.
- y_valid  input  1  systolic_array valid; high while the array is not yet streaming.
- Y  input  DATA_WIDTH*K  current Y row; word k at bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
- mem_wr_en  output  1  memory write strobe.
- addr_wr  output  ADDR_WIDTH  write word address.
- data_wr  output  DATA_WIDTH  write data.
- busy  output  1  high in ARMED/RUN.
- done  output  1  all M*K words written; sticky until reset.
- err  output  1  sticky: y_valid re-asserted during RUN.

Behaviour:
- Reset (async): state = WAIT_VALID.
  - Reset values: mem_wr_en=0, addr_wr=0, data_wr=0, busy=0, done=0, err=0.
  - Counters cleared: cap_cnt=0, drain_k=0, drain_m=0.
- States:
  - WAIT_VALID: go to ARMED on a posedge sampling y_valid=1.
  - ARMED: on the first posedge sampling y_valid=0, capture Y as row 0, set cap_cnt=1, go to RUN.
  - RUN:
    - Capture: each posedge with cap_cnt<M stores Y into row buffer[cap_cnt] and increments cap_cnt. The y_valid value is ignored for capture.
    - Drain: each posedge, if row drain_m is already stored (drain_m < cap_cnt as of the previous cycle), issue one write:
      - mem_wr_en=1
      - addr_wr = OUTPUT_BASE + drain_k*M + drain_m
      - data_wr = word drain_k of row drain_m, after RELU
    - Otherwise mem_wr_en=0 (stall).
    - Drain order: m inner (0..M-1), k outer (0..K-1). Wrap: drain_m resets to 0 and drain_k increments when drain_m = M-1.
    - After the write for (K-1, M-1) is issued, go to DONE on the next posedge.
  - DONE: mem_wr_en=0, done=1, busy=0. Stays here until reset; further Y/y_valid activity is ignored.
- Timing: let E0 be the capture edge for row 0.
  - Writes are registered at edges E0+1 .. E0+M*K. With continuous rows there is no stall.
  - done rises at edge E0+M*K+1, with mem_wr_en=0 from that edge.
- Outputs are registered. data_wr and addr_wr hold their last values when mem_wr_en=0.
- Address arithmetic is ADDR_WIDTH unsigned, with no overflow check (the caller sizes OUTPUT_BASE).
- RELU: a signed compare on DATA_WIDTH; if the word's MSB=1, write 0.
- err: y_valid=1 sampled in RUN sets err=1. Capture/drain continue unaffected.
- Reset mid-RUN: all state is aborted immediately. Writes already issued stand; nothing is replayed. The block returns to WAIT_VALID.
- y_valid held low forever after reset: the block stays in WAIT_VALID with no writes.

Decomposition:
- Shared package (conv_pkg):
  - state enum {WAIT_VALID, ARMED, RUN, DONE}.
  - Default address map constants IMG_BASE, WEIGHT_BASE, IM2COL_BASE, OUTPUT_BASE, MEM_SIZE.
  - Defaults for DATA_WIDTH/ADDR_WIDTH.
- One sub-module: out_row_buffer.
  - M x (DATA_WIDTH*K) register array.
  - Write port: row index + full row.
  - Read port: row + word index, combinational word select.
- The FSM, counters and RELU stay in the top.

Test Plan:
- Basic CHW layout:
  - Stimulus: M=20, K=5, y_valid 1 for 3 cycles then 0; row m word k = 16*m+k.
  - Required: exactly 100 writes, mem[0x3000 + k*20 + m] = 16*m+k (e.g. mem[0x3000]=0x0, mem[0x3015]=0x11, mem[0x3063]=0x134).
  - Required: done=1 at E0+101.
- Timing/order:
  - Required: first write at E0+1 is addr 0x3000 data 0x0; 20th write is addr 0x3013 data 0x130; 21st write is addr 0x3014 data 0x1.
  - Required: mem_wr_en is continuous for 100 cycles with no gaps.
- RELU=1:
  - Stimulus: row 2 word 1 = 32'hFFFF_FFF0, row 3 word 0 = 32'h0000_0007.
  - Required: mem[0x3000+1*20+2]=0 and mem[0x3003]=7.
  - Repeat with RELU=0: mem[0x3016] = FFFF_FFF0.
- Protocol error:
  - Stimulus: re-assert y_valid for 1 cycle at E0+10.
  - Required: err=1 sticky, all 100 writes still correct, done still at E0+101.
- Reset mid-run:
  - Stimulus: pulse rst_systolic asynchronously at E0+30.
  - Required: mem_wr_en=0 immediately, done=0, err=0, busy=0.
  - Required: restart with a new y_valid high→low rewrites all 100 words correctly.
- No arm:
  - Stimulus: y_valid held 0 from reset, Y toggling for 200 cycles.
  - Required: no writes, busy=0, done=0.
